// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared fetch/decode definitions. Contains the instruction and
//            address widths, the fetch state encoding, the NOP encoding, the
//            queue entry layout and a word-alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int c_INST_W = 32;
    localparam int c_ADDR_W = 64;

    // LEGv8/ARMv8 NOP encoding
    localparam logic [c_INST_W-1:0] c_NOP_INST = 32'hD503_201F;

    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    // One buffered instruction: the word plus the PC it was fetched from.
    typedef struct packed {
        logic [c_ADDR_W-1:0] pc;
        logic [c_INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [c_ADDR_W-1:0] word_align(input logic [c_ADDR_W-1:0] addr);
        return {addr[c_ADDR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : DEPTH-entry FIFO of {pc, inst} fetch entries.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            push, wdata - write an entry at the tail
//            pop         - remove the head entry (ignored when empty)
//            flush       - empty the queue; overrides push and pop
//            full, empty, count - occupancy
//            head        - entry at the head (stale when empty)
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int c_PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW:0]   r_count;
    logic            w_pop;
    logic            w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (c_PW+1)'(DEPTH));
    assign w_pop  = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch
// Purpose  : LEGv8 instruction fetch stage. Owns the PC, issues word fetches
//            to a one-cycle-latency instruction memory, buffers returned
//            words in a small queue and hands them to decode over a
//            valid/ready handshake. Handles execute redirects and halt.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            imem_req/addr/rdata      - instruction memory port
//            redirect, redirect_pc    - branch redirect from execute
//            halt                     - stop issuing new fetches
//            inst_valid/inst/inst_pc/inst_ready - decode handshake
//            stat_fetched/redirects   - event counters
// Options  : IFETCH_STATS_EN - build the event counters; otherwise the
//            stat_* outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [c_ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                  QDEPTH   = 2
)(
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [c_ADDR_W-1:0] imem_addr,
    input  logic [c_INST_W-1:0] imem_rdata,
    input  logic                redirect,
    input  logic [c_ADDR_W-1:0] redirect_pc,
    input  logic                halt,
    output logic                inst_valid,
    output logic [c_INST_W-1:0] inst,
    output logic [c_ADDR_W-1:0] inst_pc,
    input  logic                inst_ready,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_redirects
);

    localparam int         c_CW        = $clog2(QDEPTH) + 2;
    localparam logic [0:0] c_ST_RUN    = 1'(FETCH_RUN);
    localparam logic [0:0] c_ST_HALTED = 1'(FETCH_HALTED);

    logic [0:0]               r_state;
    logic [c_ADDR_W-1:0]      r_pc;
    logic [c_ADDR_W-1:0]      r_inflight_pc;
    logic                     r_inflight;
    logic                     w_q_full;
    logic                     w_q_empty;
    logic [$clog2(QDEPTH):0]  w_q_count;
    fetch_entry_t             w_q_head;
    fetch_entry_t             w_q_wdata;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_issue;
    logic [c_CW-1:0]          w_used;

    // Decode never sees the head during a redirect; the queue is being flushed.
    assign inst_valid = !w_q_empty && !redirect;
    assign w_pop      = inst_valid && inst_ready;

    // The response to last cycle's request is written this cycle. A redirect
    // in this cycle flushes the queue, which discards the response as well.
    assign w_push    = r_inflight && (!w_q_full || w_pop);
    assign w_q_wdata = '{pc: r_inflight_pc, inst: imem_rdata};

    // Slots committed = buffered + in flight. Counting the slot freed by a pop
    // in the same cycle lets the stage sustain one instruction per cycle.
    assign w_used  = c_CW'(w_q_count) + c_CW'(r_inflight) - c_CW'(w_pop);
    assign w_issue = !reset && (r_state == c_ST_RUN) && !redirect &&
                     (w_used < c_CW'(QDEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign inst      = w_q_head.inst;
    assign inst_pc   = w_q_head.pc;

    ifetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .wdata (w_q_wdata),
        .pop   (w_pop),
        .flush (redirect),
        .full  (w_q_full),
        .empty (w_q_empty),
        .count (w_q_count),
        .head  (w_q_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect) begin
                r_state <= c_ST_RUN;
                r_pc    <= word_align(redirect_pc);
            end else begin
                // Halt only gates future issue; it takes effect from the next cycle.
                if (halt) begin
                    r_state <= c_ST_HALTED;
                end
                if (w_issue) begin
                    r_pc <= r_pc + 64'd4;
                end
            end
        end
    end

`ifdef IFETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_redirects;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_fetched   <= '0;
            r_stat_redirects <= '0;
        end else begin
            if (w_pop) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if (redirect) begin
                r_stat_redirects <= r_stat_redirects + 32'd1;
            end
        end
    end

    assign stat_fetched   = r_stat_fetched;
    assign stat_redirects = r_stat_redirects;
`else
    assign stat_fetched   = '0;
    assign stat_redirects = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch
// Purpose  : Self-checking bench for ifetch. A transaction-level model keeps
//            the list of instructions fetched but not yet consumed; expected
//            fetches are queued as they are issued and compared against the
//            decode-side handshake by an independent monitor.
// Options  : IFETCH_STATS_EN - also expects live event counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch;

    localparam int          QD     = 2;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [31:0] stat_fetched;
    logic [31:0] stat_redirects;

    always #5 clk = ~clk;

    ifetch #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .stat_fetched   (stat_fetched),
        .stat_redirects (stat_redirects)
    );

    // PC-tagged instruction memory contents
    function automatic logic [31:0] memfn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A00_0000;
    endfunction

    // One-cycle-latency instruction memory
    always @(posedge clk) begin
        imem_rdata <= imem_req ? memfn(imem_addr) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] w;
        int          cyc;
    } ent_t;

    ent_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          halted = 1'b0;
    bit          prev_rst = 1'b1;
    logic [63:0] mpc = RST_PC;
    logic [31:0] nf = 32'd0;
    logic [31:0] nr = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predictor: fetch-side expectations and issue of expected entries.
    initial begin : predictor
        bit ev;
        bit ep;
        bit er;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("req_in_reset", {63'd0, imem_req}, 64'd0);
                if (prev_rst) begin
                    chk("valid_reset", {63'd0, inst_valid}, 64'd0);
                    chk("inst_reset", {32'd0, inst}, 64'd0);
                    chk("inst_pc_reset", inst_pc, 64'd0);
                    chk("addr_reset", imem_addr, RST_PC);
                    chk("stat_fetched_reset", {32'd0, stat_fetched}, 64'd0);
                    chk("stat_redirects_reset", {32'd0, stat_redirects}, 64'd0);
                end
                sb.delete();
                halted   = 1'b0;
                mpc      = RST_PC;
                nf       = 32'd0;
                nr       = 32'd0;
                prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b0;
                // A fetch issued in cycle N is presentable to decode from N+2.
                ev = !redirect && (sb.size() > 0) && ((cyc - sb[0].cyc) >= 2);
                ep = ev && inst_ready;
                er = !halted && !redirect && ((sb.size() - (ep ? 1 : 0)) < QD);
                chk("inst_valid", {63'd0, inst_valid}, {63'd0, ev});
                chk("imem_req", {63'd0, imem_req}, {63'd0, er});
                if (er) begin
                    chk("imem_addr", imem_addr, mpc);
                end
`ifdef IFETCH_STATS_EN
                chk("stat_fetched", {32'd0, stat_fetched}, {32'd0, nf});
                chk("stat_redirects", {32'd0, stat_redirects}, {32'd0, nr});
`else
                chk("stat_fetched_off", {32'd0, stat_fetched}, 64'd0);
                chk("stat_redirects_off", {32'd0, stat_redirects}, 64'd0);
`endif
                if (redirect) begin
                    sb.delete();
                    mpc    = redirect_pc & ~64'h3;
                    halted = 1'b0;
                    nr     = nr + 32'd1;
                end else begin
                    if (er) begin
                        sb.push_back('{pc: mpc, w: memfn(mpc), cyc: cyc});
                        mpc = mpc + 64'd4;
                    end
                    if (halt) begin
                        halted = 1'b1;
                    end
                    if (ep) begin
                        nf = nf + 32'd1;
                    end
                end
            end
        end
    end

    // Monitor: every handshake consumes the oldest expected instruction.
    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got inst_pc %0h expected no instruction (cycle %0d)", inst_pc, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst", {32'd0, inst}, {32'd0, e.w});
                end
            end
        end
    end

    task automatic step(input bit rs, input bit rdy, input bit rd, input logic [63:0] rpc, input bit h);
        @(posedge clk);
        #1;
        reset       = rs;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = h;
    endtask

    initial begin : driver
        bit          rs;
        bit          rdy;
        bit          rd;
        bit          h;
        logic [63:0] rpc;

        repeat (3)  step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);   // streaming
        repeat (6)  step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);   // decode stall
        repeat (5)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);                // fill with fetch in flight
        step(1'b0, 1'b1, 1'b1, 64'h1003, 1'b0);             // redirect, unaligned target
        repeat (6)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        repeat (5)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);   // halt, then held while halted
        repeat (3)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'h80, 1'b0);
        repeat (5)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b1); // redirect beats halt
        repeat (7)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);   // PC wraps to 0
        repeat (3)  step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);                // reset mid-operation
        repeat (12) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'h40, 1'b0);
        repeat (4)  step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            h   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            end else begin
                rpc = {32'($urandom), 32'($urandom)};
            end
            step(rs, rdy, rd, rpc, h);
        end

        repeat (4) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
